// File: rtl/fp_pkg.sv
// Shared RV32F definitions: mnemonic enumeration plus major-opcode and funct7
// constants used by both the instruction encoder and the FP decoder.
package fp_pkg;

  typedef enum logic [4:0] {
    FP_FLW       = 5'd0,
    FP_FSW       = 5'd1,
    FP_FMADD     = 5'd2,
    FP_FMSUB     = 5'd3,
    FP_FNMSUB    = 5'd4,
    FP_FNMADD    = 5'd5,
    FP_FADD      = 5'd6,
    FP_FSUB      = 5'd7,
    FP_FMUL      = 5'd8,
    FP_FDIV      = 5'd9,
    FP_FSQRT     = 5'd10,
    FP_FSGNJ     = 5'd11,
    FP_FSGNJN    = 5'd12,
    FP_FSGNJX    = 5'd13,
    FP_FMIN      = 5'd14,
    FP_FMAX      = 5'd15,
    FP_FCVT_W_S  = 5'd16,
    FP_FCVT_WU_S = 5'd17,
    FP_FMV_X_W   = 5'd18,
    FP_FEQ       = 5'd19,
    FP_FLT       = 5'd20,
    FP_FLE       = 5'd21,
    FP_FCLASS    = 5'd22,
    FP_FCVT_S_W  = 5'd23,
    FP_FCVT_S_WU = 5'd24,
    FP_FMV_W_X   = 5'd25
  } fp_enc_op_e;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam logic [6:0] F7_FADD      = 7'b0000000;
  localparam logic [6:0] F7_FSUB      = 7'b0000100;
  localparam logic [6:0] F7_FMUL      = 7'b0001000;
  localparam logic [6:0] F7_FDIV      = 7'b0001100;
  localparam logic [6:0] F7_FSQRT     = 7'b0101100;
  localparam logic [6:0] F7_FSGNJ     = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX   = 7'b0010100;
  localparam logic [6:0] F7_FCMP      = 7'b1010000;
  localparam logic [6:0] F7_FCVT_W_S  = 7'b1100000;
  localparam logic [6:0] F7_FCVT_S_W  = 7'b1101000;
  localparam logic [6:0] F7_FMV_X_W   = 7'b1110000;
  localparam logic [6:0] F7_FMV_W_X   = 7'b1111000;

  localparam logic [2:0] FUNCT3_FLSW  = 3'b010;

  // 101 and 110 are reserved rounding-mode encodings
  function automatic logic fp_rm_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110);
  endfunction

endpackage

// File: rtl/fp_insn_fifo.sv
// Power-of-two circular FIFO holding encoded instructions; head reads as zero
// when empty, pushes when full and pops when empty are ignored.
module fp_insn_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && (level != FULL_LVL);
  assign pop_ok    = pop && (level != '0);
  assign not_empty = (level != '0);
  assign rdata     = not_empty ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fp_insn_encoder.sv
// RV32F instruction encoder: validates and encodes a request combinationally,
// queues the 32-bit word in a FIFO and counts rejected requests.
module fp_insn_encoder
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  fp_enc_op_e             req_op_i,
  input  logic [4:0]             req_rs1_i,
  input  logic [4:0]             req_rs2_i,
  input  logic [4:0]             req_rs3_i,
  input  logic [4:0]             req_rd_i,
  input  logic [2:0]             req_rm_i,
  input  logic [11:0]            req_imm_i,
  output logic [31:0]            instr_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic                   err_o,
  output logic [7:0]             err_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0] enc;
  logic        known;
  logic        uses_rm;
  logic        op_fp;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs2_f;
  logic        reject;
  logic        accept;
  logic        push;

  always_comb begin
    enc     = '0;
    known   = 1'b1;
    uses_rm = 1'b0;
    op_fp   = 1'b0;
    f7      = '0;
    f3      = req_rm_i;
    rs2_f   = req_rs2_i;
    case (req_op_i)
      FP_FLW: enc = {req_imm_i, req_rs1_i, FUNCT3_FLSW, req_rd_i, OPC_LOAD_FP};
      FP_FSW: enc = {req_imm_i[11:5], req_rs2_i, req_rs1_i, FUNCT3_FLSW,
                     req_imm_i[4:0], OPC_STORE_FP};
      FP_FMADD, FP_FMSUB, FP_FNMSUB, FP_FNMADD: begin
        uses_rm = 1'b1;
        enc = {req_rs3_i, 2'b00, req_rs2_i, req_rs1_i, req_rm_i, req_rd_i,
               (req_op_i == FP_FMADD)  ? OPC_MADD  :
               (req_op_i == FP_FMSUB)  ? OPC_MSUB  :
               (req_op_i == FP_FNMSUB) ? OPC_NMSUB : OPC_NMADD};
      end
      FP_FADD:      begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FADD; end
      FP_FSUB:      begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FSUB; end
      FP_FMUL:      begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FMUL; end
      FP_FDIV:      begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FDIV; end
      FP_FSQRT:     begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FSQRT; rs2_f = 5'd0; end
      FP_FCVT_W_S:  begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FCVT_W_S; rs2_f = 5'd0; end
      FP_FCVT_WU_S: begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FCVT_W_S; rs2_f = 5'd1; end
      FP_FCVT_S_W:  begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FCVT_S_W; rs2_f = 5'd0; end
      FP_FCVT_S_WU: begin op_fp = 1'b1; uses_rm = 1'b1; f7 = F7_FCVT_S_W; rs2_f = 5'd1; end
      // Fixed-funct3 ops: rm input is ignored and never causes rejection
      FP_FSGNJ:     begin op_fp = 1'b1; f7 = F7_FSGNJ;   f3 = 3'b000; end
      FP_FSGNJN:    begin op_fp = 1'b1; f7 = F7_FSGNJ;   f3 = 3'b001; end
      FP_FSGNJX:    begin op_fp = 1'b1; f7 = F7_FSGNJ;   f3 = 3'b010; end
      FP_FMIN:      begin op_fp = 1'b1; f7 = F7_FMINMAX; f3 = 3'b000; end
      FP_FMAX:      begin op_fp = 1'b1; f7 = F7_FMINMAX; f3 = 3'b001; end
      FP_FLE:       begin op_fp = 1'b1; f7 = F7_FCMP;    f3 = 3'b000; end
      FP_FLT:       begin op_fp = 1'b1; f7 = F7_FCMP;    f3 = 3'b001; end
      FP_FEQ:       begin op_fp = 1'b1; f7 = F7_FCMP;    f3 = 3'b010; end
      FP_FMV_X_W:   begin op_fp = 1'b1; f7 = F7_FMV_X_W; f3 = 3'b000; rs2_f = 5'd0; end
      FP_FCLASS:    begin op_fp = 1'b1; f7 = F7_FMV_X_W; f3 = 3'b001; rs2_f = 5'd0; end
      FP_FMV_W_X:   begin op_fp = 1'b1; f7 = F7_FMV_W_X; f3 = 3'b000; rs2_f = 5'd0; end
      default:      known = 1'b0;
    endcase
    if (op_fp) enc = {f7, rs2_f, req_rs1_i, f3, req_rd_i, OPC_OP_FP};
  end

  assign reject      = !known || (uses_rm && fp_rm_reserved(req_rm_i));
  assign req_ready_o = (level_o != FULL_LVL);
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && !reject;

  fp_insn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .wdata     (enc),
    .pop       (instr_ready_i),
    .rdata     (instr_o),
    .not_empty (instr_valid_o),
    .level     (level_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= accept && reject;
      if (accept && reject && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: doc/fp_insn_encoder.md
FP_INSN_ENCODER -- requirements
Module: fp_insn_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output instruction FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  clock.
REQ-003 SHALL have port rst_ni  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port req_valid_i  input  1  encode request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-006 SHALL have port req_op_i  input  fp_enc_op_e  RV32F mnemonic to encode.
REQ-007 SHALL have ports req_rs1_i, req_rs2_i, req_rs3_i and req_rd_i  input  5 each  register indices.
REQ-008 SHALL have port req_rm_i  input  3  rounding mode for rm-carrying ops.
REQ-009 SHALL have port req_imm_i  input  12  FLW/FSW offset.
REQ-010 SHALL have port instr_o  output  32  encoded instruction at FIFO head; 0 when empty.
REQ-011 SHALL have port instr_valid_o  output  1  FIFO non-empty.
REQ-012 SHALL have port instr_ready_i  input  1  consumer pops head when high with instr_valid_o.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on a rejected request.
REQ-014 SHALL have port err_cnt_o  output  8  saturating count of rejected requests.
REQ-015 SHALL have port level_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL assert req_ready_o iff level_o < DEPTH, with no combinational dependence on instr_ready_i.
REQ-017 SHALL encode accepted requests combinationally and write them to the FIFO tail at the accepting edge, giving instr_valid_o the cycle after acceptance into an empty FIFO.
REQ-018 SHALL encode FLW as {imm,rs1,010,rd,0000111} and FSW as {imm[11:5],rs2,rs1,010,imm[4:0],0100111}.
REQ-019 SHALL encode FMADD/FMSUB/FNMSUB/FNMADD as {rs3,00,rs2,rs1,rm,rd,op}, with op 1000011/1000111/1001011/1001111.
REQ-020 SHALL encode FADD/FSUB/FMUL/FDIV with funct7 0000000/0000100/0001000/0001100 and rm from req_rm_i.
REQ-021 SHALL encode FSQRT with funct7 0101100 and rs2 forced to 0.
REQ-022 SHALL encode FCVT.W.S/WU.S with funct7 1100000 and rs2 0/1, and FCVT.S.W/WU with funct7 1101000 and rs2 0/1.
REQ-023 SHALL use a fixed funct3 replacing req_rm_i: FSGNJ/N/X 000/001/010 (funct7 0010000), FMIN/FMAX 000/001 (funct7 0010100), FLE/FLT/FEQ 000/001/010 (funct7 1010000).
REQ-024 SHALL use a fixed funct3 replacing req_rm_i: FMV.X.W 000 and FCLASS 001 (funct7 1110000, rs2 0), and FMV.W.X 000 (funct7 1111000, rs2 0).
REQ-025 SHALL reject, for rm-carrying ops only, a request with req_rm_i of 101 or 110 or an undefined req_op_i.
REQ-026 SHALL handle a rejected request as follows: accepted by handshake, not written, err_o high the next cycle, err_cnt_o incremented and saturating at 255.
REQ-027 SHALL, on simultaneous push and pop, leave level_o unchanged and write the new tail while the head advances.
REQ-028 SHALL, when full, hold req_ready_o low even if a pop occurs in the same cycle.
REQ-029 SHALL wrap read and write pointers modulo DEPTH, and SHALL ignore a pop when empty.
REQ-030 SHALL keep instr_o stable while instr_valid_o is high and instr_ready_i is low.

Reset
REQ-031 SHALL, while rst_ni is low at a clock edge, clear pointers, level_o, err_o and err_cnt_o, giving instr_valid_o=0 and instr_o=0.
REQ-032 SHALL give req_ready_o=1 in the first cycle after reset release.
REQ-033 SHALL discard in-flight FIFO contents on reset asserted mid-operation.

Structure
REQ-034 SHALL take fp_enc_op_e and the opcode/funct7 constants from fp_pkg, shared with the FP decoder.
REQ-035 SHALL use a single sub-module, fp_insn_fifo (parameterised DEPTH, width 32), for storage.

Verification
REQ-036 SHALL cover: FADD rd=1, rs1=2, rs2=3, rm=000 -> instr_o=0x003100D3, one cycle after acceptance.
REQ-037 SHALL cover: FLW rd=5, rs1=10, imm=0x008 -> 0x00852287; FMADD rd=4, rs1=1, rs2=2, rs3=3, rm=111 -> 0x1820F243.
REQ-038 SHALL cover: FMUL with rm=101 -> err_o pulse, err_cnt_o=1, level_o unchanged; FSGNJX with rm=101 -> accepted, funct3=010.
REQ-039 SHALL cover: 5 back-to-back requests with instr_ready_i=0, DEPTH=4 -> req_ready_o low after 4th, level_o=4, then pops drain in order.
REQ-040 SHALL cover: full FIFO with instr_ready_i=1 and req_valid_i=1 -> pop occurs, no push that cycle, push next cycle; reset with level_o=3 -> empty next cycle.
